// File: rtl/snax_hwpe_pkg.sv
// rtl/snax_hwpe_pkg.sv - shared types and constants for the reqrsp-to-HWPE TCDM adapter
package snax_hwpe_pkg;

    // Adapter FSM states: one outstanding request, split into up to two 32-bit beats
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ0 = 3'd1,
        REQ1 = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } hwpe_state_e;

    // Which 32-bit half of the 64-bit word a beat addresses
    localparam logic BEAT_LO = 1'b0;
    localparam logic BEAT_HI = 1'b1;

    // Atomic opcodes carried on q.amo; the adapter treats all of them as plain accesses
    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

    typedef struct packed {
        logic [47:0] addr;
        logic        write;
        logic [63:0] data;
        logic [7:0]  strb;
        amo_op_e     amo;
    } tcdm_q_t;

    typedef struct packed {
        tcdm_q_t q;
        logic    q_valid;
    } tcdm_req_chan_t;

    typedef struct packed {
        logic [63:0] data;
    } tcdm_p_t;

    typedef struct packed {
        logic    q_ready;
        tcdm_p_t p;
        logic    p_valid;
    } tcdm_rsp_chan_t;

    // Word-aligned byte address of the selected half of the 64-bit word
    function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic sel);
        return {addr[31:3], sel, 2'b00};
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// rtl/hwpe_stream_intf_tcdm.sv - 32-bit HWPE TCDM port bundle
interface hwpe_stream_intf_tcdm;

    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );

endinterface

// File: rtl/snax_reqrsp_to_hwpe.sv
// rtl/snax_reqrsp_to_hwpe.sv - 64-bit reqrsp TCDM request to 32-bit HWPE TCDM beats
module snax_reqrsp_to_hwpe
    import snax_hwpe_pkg::*;
#(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 64,
    parameter type tcdm_req_t = tcdm_req_chan_t,
    parameter type tcdm_rsp_t = tcdm_rsp_chan_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  tcdm_req_t            tcdm_req_i,
    output tcdm_rsp_t            tcdm_rsp_o,
    hwpe_stream_intf_tcdm.master hwpe_tcdm_master
);

    hwpe_state_e state_q, state_d;

    tcdm_req_t   req_q;
    logic [1:0]  gnt_cnt_q;
    logic [1:0]  rsp_cnt_q;
    logic [31:0] rdata_lo_q;
    logic [31:0] rdata_hi_q;

    logic [AddrWidth-1:0] q_addr;
    logic [DataWidth-1:0] q_wdata;
    logic [7:0]           q_strb;

    logic       lo_en;
    logic       hi_en;
    logic       two_beats;
    logic [1:0] n_beats;
    logic       first_sel;
    logic       cur_sel;
    logic       rsp_sel;
    logic       q_hs;
    logic       beat_req;
    logic       beat_gnt;
    logic       rsp_accept;
    logic       last_rsp;

    assign q_addr  = req_q.q.addr;
    assign q_wdata = req_q.q.data;
    assign q_strb  = req_q.q.strb;

    // An all-zero strobe still issues one (empty) lower beat so every request gets a response
    assign lo_en     = (q_strb[3:0] != 4'h0) || (q_strb == 8'h00);
    assign hi_en     = (q_strb[7:4] != 4'h0);
    assign two_beats = lo_en && hi_en;
    assign n_beats   = {1'b0, lo_en} + {1'b0, hi_en};
    assign first_sel = lo_en ? BEAT_LO : BEAT_HI;
    assign cur_sel   = (state_q == REQ1) ? BEAT_HI : first_sel;

    // Responses come back in grant order, so the response count identifies the half
    assign rsp_sel = (rsp_cnt_q == 2'd0) ? first_sel : BEAT_HI;

    assign q_hs       = tcdm_req_i.q_valid && (state_q == IDLE);
    assign beat_req   = (state_q == REQ0) || (state_q == REQ1);
    assign beat_gnt   = beat_req && hwpe_tcdm_master.gnt;
    assign rsp_accept = hwpe_tcdm_master.r_valid && (rsp_cnt_q < gnt_cnt_q) &&
                        ((state_q == REQ1) || (state_q == WAIT));
    assign last_rsp   = rsp_accept && ((rsp_cnt_q + 2'd1) == n_beats);

    // amo is deliberately ignored and the upper address bits are outside the 32-bit HWPE space
    logic unused_bits;
    assign unused_bits = ^{req_q.q_valid, req_q.q.amo, q_addr[AddrWidth-1:32], q_addr[2:0]};

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (tcdm_req_i.q_valid) state_d = REQ0;
            REQ0: if (hwpe_tcdm_master.gnt) state_d = two_beats ? REQ1 : WAIT;
            REQ1: if (hwpe_tcdm_master.gnt) state_d = WAIT;
            WAIT: if (last_rsp) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, grant/response counting and read-data merge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q      <= '0;
            gnt_cnt_q  <= 2'd0;
            rsp_cnt_q  <= 2'd0;
            rdata_lo_q <= 32'h0;
            rdata_hi_q <= 32'h0;
        end else if (q_hs) begin
            req_q      <= tcdm_req_i;
            gnt_cnt_q  <= 2'd0;
            rsp_cnt_q  <= 2'd0;
            rdata_lo_q <= 32'h0;
            rdata_hi_q <= 32'h0;
        end else begin
            if (beat_gnt) begin
                gnt_cnt_q <= gnt_cnt_q + 2'd1;
            end
            if (rsp_accept) begin
                rsp_cnt_q <= rsp_cnt_q + 2'd1;
                if (!req_q.q.write) begin
                    if (rsp_sel == BEAT_LO) begin
                        rdata_lo_q <= hwpe_tcdm_master.r_data;
                    end else begin
                        rdata_hi_q <= hwpe_tcdm_master.r_data;
                    end
                end
            end
        end
    end

    // HWPE beat outputs: idle values whenever no beat is being requested
    always_comb begin
        hwpe_tcdm_master.req  = 1'b0;
        hwpe_tcdm_master.add  = 32'h0;
        hwpe_tcdm_master.wen  = 1'b1;
        hwpe_tcdm_master.be   = 4'h0;
        hwpe_tcdm_master.data = 32'h0;
        if (beat_req) begin
            hwpe_tcdm_master.req  = 1'b1;
            hwpe_tcdm_master.add  = beat_addr(q_addr[31:0], cur_sel);
            hwpe_tcdm_master.wen  = !req_q.q.write;
            hwpe_tcdm_master.be   = (cur_sel == BEAT_HI) ? q_strb[7:4] : q_strb[3:0];
            hwpe_tcdm_master.data = (cur_sel == BEAT_HI) ? q_wdata[63:32] : q_wdata[31:0];
        end
    end

    // Initiator-side handshake and single-cycle response
    always_comb begin
        tcdm_rsp_o         = '0;
        tcdm_rsp_o.q_ready = (state_q == IDLE);
        tcdm_rsp_o.p_valid = (state_q == RESP);
        if (state_q == RESP) begin
            tcdm_rsp_o.p.data = {rdata_hi_q, rdata_lo_q};
        end
    end

endmodule

// File: tb/tb_snax_reqrsp_to_hwpe.sv
// tb/tb_snax_reqrsp_to_hwpe.sv - self-checking bench for snax_reqrsp_to_hwpe
module tb_snax_reqrsp_to_hwpe;
    import snax_hwpe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    tcdm_req_chan_t tcdm_req;
    tcdm_rsp_chan_t tcdm_rsp;

    hwpe_stream_intf_tcdm tcdm_if();

    snax_reqrsp_to_hwpe #(
        .AddrWidth (48),
        .DataWidth (64),
        .tcdm_req_t(tcdm_req_chan_t),
        .tcdm_rsp_t(tcdm_rsp_chan_t)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .tcdm_req_i      (tcdm_req),
        .tcdm_rsp_o      (tcdm_rsp),
        .hwpe_tcdm_master(tcdm_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] add;
        logic [31:0] data;
        logic [3:0]  be;
        logic        wen;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        int          due;
    } pend_t;

    typedef struct {
        logic [47:0] addr;
        logic        write;
        logic [63:0] data;
        logic [7:0]  strb;
        int          gd;
        int          rd;
        logic [31:0] r0;
        logic [31:0] r1;
        int          exp_nb;
        logic [31:0] exp_add0;
        logic [63:0] exp_pdata;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    int cyc = 0;
    int gnt_dly = 0;
    int rv_dly = 1;
    logic [31:0] rd_vals[2];
    int gnt_idx = 0;
    int wait_cnt = 0;
    bit stalled = 1'b0;
    beat_t prev_beat;
    beat_t obs_beats[$];
    beat_t exp_beats[$];
    pend_t pend[$];
    int req_cycles = 0;
    int stall_bad = 0;
    int pv_count = 0;
    int pv_total = 0;
    int pv_cyc = 0;
    int last_rv_cyc = 0;
    logic [63:0] pv_data[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory-side responder and output monitor, all on the falling edge
    always @(negedge clk) begin : responder
        beat_t cur;
        cyc++;
        cur = beat_t'{tcdm_if.add, tcdm_if.data, tcdm_if.be, tcdm_if.wen};
        tcdm_if.gnt     = 1'b0;
        tcdm_if.r_valid = 1'b0;
        tcdm_if.r_data  = $urandom();
        if (pend.size() > 0 && pend[0].due == cyc) begin
            tcdm_if.r_valid = 1'b1;
            tcdm_if.r_data  = pend[0].rdata;
            void'(pend.pop_front());
            last_rv_cyc = cyc;
        end
        if (tcdm_if.req) begin
            req_cycles++;
            if (stalled && cur !== prev_beat) stall_bad++;
            if (wait_cnt >= gnt_dly) begin
                tcdm_if.gnt = 1'b1;
                obs_beats.push_back(cur);
                pend.push_back(pend_t'{rd_vals[(gnt_idx > 1) ? 1 : gnt_idx], cyc + rv_dly});
                gnt_idx++;
                wait_cnt = 0;
                stalled = 1'b0;
            end else begin
                wait_cnt++;
                stalled = 1'b1;
                prev_beat = cur;
            end
        end else begin
            wait_cnt = 0;
            stalled = 1'b0;
        end
        if (tcdm_rsp.p_valid) begin
            pv_count++;
            pv_total++;
            pv_cyc = cyc;
            pv_data.push_back(tcdm_rsp.p.data);
        end
    end

    // Reference: beats and merged response derived from the strobe/address rules
    task automatic model(input vec_t v, output logic [63:0] pd);
        bit lo, hi;
        exp_beats.delete();
        lo = (v.strb[3:0] != 4'h0) || (v.strb == 8'h00);
        hi = (v.strb[7:4] != 4'h0);
        pd = 64'h0;
        if (lo) begin
            exp_beats.push_back(beat_t'{{v.addr[31:3], 3'b000}, v.data[31:0], v.strb[3:0], !v.write});
            if (!v.write) pd[31:0] = v.r0;
        end
        if (hi) begin
            exp_beats.push_back(beat_t'{{v.addr[31:3], 3'b100}, v.data[63:32], v.strb[7:4], !v.write});
            if (!v.write) pd[63:32] = lo ? v.r1 : v.r0;
        end
    endtask

    task automatic arm(input vec_t v);
        gnt_dly = v.gd;
        rv_dly = v.rd;
        rd_vals[0] = v.r0;
        rd_vals[1] = v.r1;
        gnt_idx = 0;
        obs_beats.delete();
        pv_data.delete();
        pv_count = 0;
        req_cycles = 0;
        stall_bad = 0;
        tcdm_req.q.addr  = v.addr;
        tcdm_req.q.write = v.write;
        tcdm_req.q.data  = v.data;
        tcdm_req.q.strb  = v.strb;
        tcdm_req.q.amo   = (v.addr[4]) ? AMOAdd : AMONone;
        tcdm_req.q_valid = 1'b1;
    endtask

    task automatic run_txn(input vec_t v, input bit hold, input bit directed);
        logic [63:0] exp_pd;
        int n;
        int busy_bad;
        int bad;
        busy_bad = 0;
        model(v, exp_pd);
        arm(v);
        n = 0;
        while (!tcdm_rsp.q_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 64'(n < 100), 64'd1);
        @(negedge clk);
        if (!hold) tcdm_req.q_valid = 1'b0;
        n = 0;
        while (pv_count == 0 && n < 200) begin
            if (tcdm_rsp.q_ready) busy_bad++;
            @(negedge clk);
            n++;
        end
        chk("pvalid_seen", 64'(pv_count != 0), 64'd1);
        chk("pdata", (pv_data.size() != 0) ? pv_data[0] : ~exp_pd, exp_pd);
        chk("nbeats", 64'(obs_beats.size()), 64'(exp_beats.size()));
        bad = 0;
        foreach (exp_beats[i]) begin
            if (i >= obs_beats.size()) bad++;
            else if (obs_beats[i] !== exp_beats[i]) bad++;
        end
        chk("beat_fields", 64'(bad), 64'd0);
        chk("req_cycles", 64'(req_cycles), 64'(exp_beats.size() * (v.gd + 1)));
        chk("stall_stable", 64'(stall_bad), 64'd0);
        chk("q_ready_busy", 64'(busy_bad), 64'd0);
        chk("pvalid_latency", 64'(pv_cyc - last_rv_cyc), 64'd1);
        if (directed) begin
            chk("tab_pdata", (pv_data.size() != 0) ? pv_data[0] : ~v.exp_pdata, v.exp_pdata);
            chk("tab_nbeats", 64'(obs_beats.size()), 64'(v.exp_nb));
            chk("tab_add0", (obs_beats.size() != 0) ? 64'(obs_beats[0].add) : 64'hFFFF_FFFF_FFFF_FFFF,
                64'(v.exp_add0));
        end
        if (!hold) begin
            repeat (3) @(negedge clk);
            chk("pvalid_once", 64'(pv_count), 64'd1);
        end
    endtask

    vec_t tab[6];
    vec_t v;

    initial begin
        int pv_start;
        tab[0] = '{48'h1000, 1'b0, 64'h0,                   8'h0F, 0, 1, 32'hDEADBEEF, 32'h0,        1, 32'h1000, 64'h00000000_DEADBEEF};
        tab[1] = '{48'h2000, 1'b1, 64'h11223344_55667788,   8'hFF, 0, 1, 32'hA5A5A5A5, 32'h5A5A5A5A, 2, 32'h2000, 64'h0};
        tab[2] = '{48'h4000, 1'b0, 64'h0,                   8'hFF, 3, 4, 32'hCAFEF00D, 32'h0BADC0DE, 2, 32'h4000, 64'h0BADC0DE_CAFEF00D};
        tab[3] = '{48'h3004, 1'b1, 64'hAABBCCDD_01234567,   8'hF0, 1, 2, 32'h77777777, 32'h0,        1, 32'h3004, 64'h0};
        tab[4] = '{48'h5008, 1'b0, 64'h0,                   8'h00, 0, 1, 32'h12345678, 32'h0,        1, 32'h5008, 64'h00000000_12345678};
        tab[5] = '{48'h6000, 1'b0, 64'h0,                   8'hF0, 2, 1, 32'h9ABCDEF0, 32'h0,        1, 32'h6004, 64'h9ABCDEF0_00000000};

        rst = 1'b1;
        tcdm_req = '0;
        repeat (3) @(negedge clk);
        chk("rst_q_ready", 64'(tcdm_rsp.q_ready), 64'd1);
        chk("rst_p_valid", 64'(tcdm_rsp.p_valid), 64'd0);
        chk("rst_p_data", tcdm_rsp.p.data, 64'd0);
        chk("rst_req", 64'(tcdm_if.req), 64'd0);
        chk("rst_add", 64'(tcdm_if.add), 64'd0);
        chk("rst_wen", 64'(tcdm_if.wen), 64'd1);
        chk("rst_be", 64'(tcdm_if.be), 64'd0);
        chk("rst_data", 64'(tcdm_if.data), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(tab[i], 1'b0, 1'b1);

        // Reset while waiting for the response; the late r_valid must be ignored
        v = '{48'h7000, 1'b0, 64'h0, 8'h0F, 0, 6, 32'h55AA55AA, 32'h0, 1, 32'h7000, 64'h0};
        arm(v);
        while (!tcdm_rsp.q_ready) @(negedge clk);
        @(negedge clk);
        tcdm_req.q_valid = 1'b0;
        @(negedge clk);
        chk("wait_req_low", 64'(tcdm_if.req), 64'd0);
        chk("wait_q_ready_low", 64'(tcdm_rsp.q_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_req", 64'(tcdm_if.req), 64'd0);
        chk("abort_q_ready", 64'(tcdm_rsp.q_ready), 64'd1);
        repeat (10) @(negedge clk);
        chk("abort_no_pvalid", 64'(pv_count), 64'd0);
        run_txn(tab[0], 1'b0, 1'b1);

        // Back-to-back: q_valid stays high across three reads
        pv_start = pv_total;
        for (int i = 0; i < 3; i++) begin
            v.addr  = 48'h8000 + 48'(i * 8);
            v.write = 1'b0;
            v.data  = 64'h0;
            v.strb  = (i == 1) ? 8'hFF : 8'h0F;
            v.gd    = i;
            v.rd    = 1;
            v.r0    = 32'h1000_0000 + 32'(i);
            v.r1    = 32'h2000_0000 + 32'(i);
            run_txn(v, 1'b1, 1'b0);
        end
        tcdm_req.q_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_pvalid_count", 64'(pv_total - pv_start), 64'd3);

        // Randomized transactions against the reference
        for (int i = 0; i < 40; i++) begin
            v.addr  = {16'($urandom()), 32'($urandom())};
            v.write = 1'($urandom());
            v.data  = {32'($urandom()), 32'($urandom())};
            case ($urandom_range(0, 4))
                0: v.strb = 8'h00;
                1: v.strb = 8'h0F;
                2: v.strb = 8'hF0;
                3: v.strb = 8'hFF;
                default: v.strb = 8'($urandom());
            endcase
            v.gd = $urandom_range(0, 3);
            v.rd = $urandom_range(1, 5);
            v.r0 = $urandom();
            v.r1 = $urandom();
            run_txn(v, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/snax_reqrsp_to_hwpe.md
SNAX_REQRSP_TO_HWPE -- requirements
Module: snax_reqrsp_to_hwpe

Interface
REQ-001 SHALL have parameter AddrWidth, default 48, TCDM request address width.
REQ-002 SHALL have parameter DataWidth, default 64, TCDM data width; only 64 supported.
REQ-003 SHALL have parameter tcdm_req_t, default logic, TCDM request type (q, q_valid).
REQ-004 SHALL have parameter tcdm_rsp_t, default logic, TCDM response type (q_ready, p, p_valid).
REQ-005 SHALL have port clk_i  input  1  clock; one clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port tcdm_req_i  input  tcdm_req_t  TCDM request from initiator (q.addr, q.write, q.data, q.strb, q.amo, q_valid).
REQ-008 SHALL have port tcdm_rsp_o  output  tcdm_rsp_t  TCDM response to initiator (q_ready, p.data, p_valid).
REQ-009 SHALL have port hwpe_tcdm_master  hwpe_stream_intf_tcdm.master  32-bit HWPE TCDM master (req, gnt, add, wen, be, data, r_data, r_valid).

Function
REQ-010 SHALL allow one outstanding TCDM request; q_ready high only in state IDLE.
REQ-011 SHALL register q on q_valid & q_ready and split it into beats: lower beat if strb[3:0]!=0, upper beat if strb[7:4]!=0; both set -> lower first, then upper; strb==0 -> one lower beat with be=4'b0000.
REQ-012 SHALL drive per beat: add = {q.addr[31:3], 3'b000} for lower, {q.addr[31:3], 3'b100} for upper; data = matching 32-bit half of q.data; be = matching strb nibble; wen = !q.write (HWPE wen=0 writes).
REQ-013 SHALL use states IDLE -> REQ0 -> (REQ1 if two beats) -> WAIT -> RESP -> IDLE.
REQ-014 SHALL assert req the cycle after q handshake; hold req, add, wen, be, data stable until gnt sampled high; advance state on the req & gnt cycle.
REQ-015 SHALL count one r_valid per granted beat, in order, writes included; r_valid may arrive while a later beat is still requesting (REQ1), including in the same cycle as gnt.
REQ-016 SHALL on a read capture r_data into p.data[31:0] (lower beat) or p.data[63:32] (upper beat); the unaccessed half reads 0.
REQ-017 SHALL enter RESP the cycle after the last expected r_valid and assert p_valid for exactly one cycle; writes also get p_valid, with p.data = 0.
REQ-018 SHALL give 2-cycle minimum q-handshake-to-req-drop latency for one beat with gnt immediate; p_valid one cycle after last r_valid.
REQ-019 SHALL treat q.amo other than AMONone as a plain read/write per q.write.
REQ-020 SHALL ignore r_valid in IDLE, and any r_valid beyond the expected count.
REQ-021 SHALL keep req low outside REQ0/REQ1.

Reset
REQ-022 SHALL on rst_i high at any rising edge, mid-operation included, go to IDLE and clear the beat and response counters and captured data.
REQ-023 SHALL have these output values during and after reset: q_ready=1 after reset (IDLE), p_valid=0, p.data=0, req=0, add=0, wen=1, be=0, data=0.
REQ-024 SHALL let a transaction aborted by reset produce no p_valid; its late r_valid is ignored per REQ-020.

Structure
REQ-025 SHALL place the state enum (IDLE, REQ0, REQ1, WAIT, RESP) and the beat-select constants in shared package snax_hwpe_pkg.
REQ-026 SHALL be one module with no sub-module; the FSM and beat register are flat, and no FIFO is needed because only one request is outstanding.

Verification
REQ-027 SHALL test read with strb=8'h0F, addr=0x1000, gnt immediate, r_data=0xDEADBEEF after 1 cycle -> one HWPE beat add=0x1000, wen=1, be=4'hF; p.data=0x00000000_DEADBEEF, p_valid one cycle.
REQ-028 SHALL test write with strb=8'hFF, addr=0x2000, data=0x11223344_55667788 -> beats (0x2000, 0x55667788, be=F) then (0x2004, 0x11223344, be=F), wen=0; p_valid once after second r_valid.
REQ-029 SHALL test read with strb=8'hFF, gnt delayed 3 cycles per beat, beat-0 r_valid in the same cycle as beat-1 gnt -> req/add stable while stalled; merged p.data = {rdata1, rdata0}.
REQ-030 SHALL test write with strb=8'hF0, addr=0x3004 -> single beat add=0x3004, be=4'hF, data=q.data[63:32]; q_ready low until RESP completes.
REQ-031 SHALL test rst_i asserted in WAIT, then a stray r_valid -> no p_valid; req=0; q_ready=1 next cycle; next read completes normally.
REQ-032 SHALL test back-to-back q_valid held high across 3 reads -> each accepted only in IDLE; exactly 3 p_valid in order.
